fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/seq_down_counter.sv | 30 +++
 rtl/fetch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Control-path definitions shared by the fetch sequencer and the decoder:
// sequencer state encodings, ALU op codes, branch types and counter sizing.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_FETCH_IMM = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_INT_ENTRY = 3'd4
  } seq_state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_ST   = 4'd9;
  localparam logic [3:0] OP_BR   = 4'd10;
  localparam logic [3:0] OP_CALL = 4'd11;
  localparam logic [3:0] OP_IMM  = 4'd12;
  localparam logic [3:0] OP_RET  = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_ALWAYS = 3'd1,
    BR_EQ     = 3'd2,
    BR_NE     = 3'd3,
    BR_LT     = 3'd4,
    BR_GE     = 3'd5,
    BR_CALL   = 3'd6,
    BR_RET    = 3'd7
  } br_type_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter shared by the fetch sequencer's multi-cycle states.
// Load has priority over decrement; decrement saturates at zero.
module seq_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         is_one
);

  logic [W-1:0] value_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_val;
    end else if (dec && (value_reg != '0)) begin
      value_reg <= value_reg - 1'b1;
    end
  end

  assign value  = value_reg;
  assign is_one = (value_reg == W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: stalls, immediate-word fetch, branch flush and
// interrupt entry. Interrupt support is built only when FETCH_SEQ_INTR_EN is defined.
module fetch_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 4,
  parameter int IMM_OPCODE   = 12,
  parameter int IMM_WORDS    = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int INT_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                intr,
  input  logic                load_use,
  input  logic                branch_taken,
  output logic                pc_write_en,
  output logic                if_id_write_en,
  output logic                inject_bubble,
  output logic                inject_int,
  output logic                imm_valid,
  output logic                int_ack,
  output logic [2:0]          state_o
);

  localparam int CNT_MAX = max_of3(IMM_WORDS, FLUSH_CYCLES - 1, INT_CYCLES);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_is_one;
  logic             cnt_done;
  logic             is_imm_op;

  seq_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .is_one   (cnt_is_one)
  );

  // A zero count also ends a sequence so a corrupted counter cannot hang a state.
  assign cnt_done  = cnt_is_one || (cnt_value == '0);
  assign is_imm_op = (opcode == OPCODE_W'(IMM_OPCODE));

`ifdef FETCH_SEQ_INTR_EN
  logic int_pending_reg;

  // A request arriving in the acknowledge cycle wins, so a held level is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_pending_reg <= 1'b0;
    end else begin
      int_pending_reg <= intr || (int_pending_reg && !int_ack);
    end
  end
`else
  logic unused_intr;
  assign unused_intr = intr;
`endif

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    inject_bubble  = 1'b0;
    inject_int     = 1'b0;
    imm_valid      = 1'b0;
    int_ack        = 1'b0;
    state_next     = state_reg;
    cnt_load       = 1'b0;
    cnt_load_val   = '0;
    cnt_dec        = 1'b0;

    case (state_reg)
      ST_RESET: begin
        inject_bubble = 1'b1;
        state_next    = ST_FETCH;
      end

      ST_FETCH: begin
        if (branch_taken) begin
          inject_bubble = 1'b1;
          cnt_load      = 1'b1;
          cnt_load_val  = CNT_W'(FLUSH_CYCLES - 1);
          state_next    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_FETCH;
`ifdef FETCH_SEQ_INTR_EN
        end else if (int_pending_reg) begin
          inject_int     = 1'b1;
          inject_bubble  = 1'b1;
          if_id_write_en = 1'b0;
          cnt_load       = 1'b1;
          cnt_load_val   = CNT_W'(INT_CYCLES);
          state_next     = ST_INT_ENTRY;
`endif
        end else if (load_use) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          inject_bubble  = 1'b1;
        end else if (is_imm_op) begin
          if_id_write_en = 1'b0;
          inject_bubble  = 1'b1;
          cnt_load       = 1'b1;
          cnt_load_val   = CNT_W'(IMM_WORDS);
          state_next     = ST_FETCH_IMM;
        end
      end

      ST_FETCH_IMM: begin
        if (branch_taken) begin
          inject_bubble = 1'b1;
          cnt_load      = 1'b1;
          cnt_load_val  = CNT_W'(FLUSH_CYCLES - 1);
          state_next    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_FETCH;
        end else begin
          imm_valid = 1'b1;
          cnt_dec   = 1'b1;
          if (cnt_done) state_next = ST_FETCH;
        end
      end

      ST_FLUSH: begin
        inject_bubble = 1'b1;
        cnt_dec       = 1'b1;
        if (cnt_done) state_next = ST_FETCH;
      end

`ifdef FETCH_SEQ_INTR_EN
      ST_INT_ENTRY: begin
        inject_bubble = 1'b1;
        cnt_dec       = 1'b1;
        if (cnt_done) begin
          int_ack    = 1'b1;
          state_next = ST_FETCH;
        end else begin
          pc_write_en = 1'b0;
        end
      end
`endif

      default: begin
        cnt_load     = 1'b1;
        cnt_load_val = '0;
        state_next   = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Cycle-by-cycle scoreboard bench for fetch_sequencer: each step pushes the
// expected state/outputs, and a negedge monitor pops and compares them.
module tb_fetch_sequencer;

  localparam logic [2:0] S_RST = 3'd0;
  localparam logic [2:0] S_FET = 3'd1;
  localparam logic [2:0] S_IMM = 3'd2;
  localparam logic [2:0] S_FLS = 3'd3;
  localparam logic [2:0] S_INT = 3'd4;

  // Output vector order: pc_write_en, if_id_write_en, inject_bubble, inject_int, imm_valid, int_ack
  localparam logic [5:0] O_IDLE  = 6'b110000;
  localparam logic [5:0] O_BUB   = 6'b111000;
  localparam logic [5:0] O_IMMS  = 6'b101000;
  localparam logic [5:0] O_IMMV  = 6'b110010;
  localparam logic [5:0] O_STALL = 6'b001000;
  localparam logic [5:0] O_INTS  = 6'b101100;
  localparam logic [5:0] O_INTW  = 6'b011000;
  localparam logic [5:0] O_INTA  = 6'b111001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       intr;
  logic       load_use;
  logic       branch_taken;
  logic       pc_write_en;
  logic       if_id_write_en;
  logic       inject_bubble;
  logic       inject_int;
  logic       imm_valid;
  logic       int_ack;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .OPCODE_W     (4),
    .IMM_OPCODE   (12),
    .IMM_WORDS    (2),
    .FLUSH_CYCLES (3),
    .INT_CYCLES   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .intr           (intr),
    .load_use       (load_use),
    .branch_taken   (branch_taken),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .inject_bubble  (inject_bubble),
    .inject_int     (inject_int),
    .imm_valid      (imm_valid),
    .int_ack        (int_ack),
    .state_o        (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [8:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {23'd0, state_o, pc_write_en, if_id_write_en, inject_bubble,
                inject_int, imm_valid, int_ack}, {23'd0, e});
    end
  end

  task automatic step(input string tag, input logic r, input logic br, input logic lu,
                      input logic irq, input logic [3:0] op,
                      input logic [2:0] st, input logic [5:0] outs);
    rst          = r;
    branch_taken = br;
    load_use     = lu;
    intr         = irq;
    opcode       = op;
    exp_q.push_back({st, outs});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = 4'd0; intr = 1'b0; load_use = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;

    // reset and release: one bubble cycle, then FETCH
    step("rst_hold0",   1, 0, 0, 0, 4'd0,  S_RST, O_BUB);
    step("rst_hold1",   1, 0, 0, 0, 4'd0,  S_RST, O_BUB);
    step("rst_release", 0, 0, 0, 0, 4'd0,  S_RST, O_BUB);
    step("fetch_idle",  0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    // immediate instruction, two extra words
    step("imm_start",   0, 0, 0, 0, 4'd12, S_FET, O_IMMS);
    step("imm_word1",   0, 0, 0, 0, 4'd0,  S_IMM, O_IMMV);
    step("imm_word2",   0, 0, 0, 0, 4'd0,  S_IMM, O_IMMV);
    step("imm_done",    0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    // taken branch: three bubble cycles
    step("br_take",     0, 1, 0, 0, 4'd0,  S_FET, O_BUB);
    step("br_flush1",   0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("br_flush2",   0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("br_done",     0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    // load-use held two cycles
    step("lu_stall1",   0, 0, 1, 0, 4'd0,  S_FET, O_STALL);
    step("lu_stall2",   0, 0, 1, 0, 4'd0,  S_FET, O_STALL);
    step("lu_done",     0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    // branch aborts an immediate fetch
    step("abort_imm",   0, 0, 0, 0, 4'd12, S_FET, O_IMMS);
    step("abort_br",    0, 1, 0, 0, 4'd0,  S_IMM, O_BUB);
    step("abort_fl1",   0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("abort_fl2",   0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("abort_done",  0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    // priority: branch over load-use, load-use over immediate
    step("prio_br_lu",  0, 1, 1, 0, 4'd0,  S_FET, O_BUB);
    step("prio_fl1",    0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("prio_fl2",    0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("prio_fetch",  0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);
    step("prio_lu_imm", 0, 0, 1, 0, 4'd12, S_FET, O_STALL);
    step("prio_after",  0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

`ifdef FETCH_SEQ_INTR_EN
    // interrupt pulse during FETCH_IMM is deferred until the sequence ends
    step("irq_imm",     0, 0, 0, 0, 4'd12, S_FET, O_IMMS);
    step("irq_pulse",   0, 0, 0, 1, 4'd0,  S_IMM, O_IMMV);
    step("irq_defer",   0, 0, 0, 0, 4'd0,  S_IMM, O_IMMV);
    step("irq_start",   0, 0, 0, 0, 4'd0,  S_FET, O_INTS);
    step("irq_push",    0, 0, 0, 0, 4'd0,  S_INT, O_INTW);
    step("irq_ack",     0, 0, 0, 0, 4'd0,  S_INT, O_INTA);
    step("irq_clear1",  0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);
    step("irq_clear2",  0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    // level dropped before ack: exactly one entry
    step("lvl_raise",   0, 0, 0, 1, 4'd0,  S_FET, O_IDLE);
    step("lvl_start",   0, 0, 0, 1, 4'd0,  S_FET, O_INTS);
    step("lvl_push",    0, 0, 0, 1, 4'd0,  S_INT, O_INTW);
    step("lvl_ack",     0, 0, 0, 0, 4'd0,  S_INT, O_INTA);
    step("lvl_idle",    0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    // level held through ack: a second entry follows
    step("held_raise",  0, 0, 0, 1, 4'd0,  S_FET, O_IDLE);
    step("held_start",  0, 0, 0, 1, 4'd0,  S_FET, O_INTS);
    step("held_push",   0, 0, 0, 1, 4'd0,  S_INT, O_INTW);
    step("held_ack",    0, 0, 0, 1, 4'd0,  S_INT, O_INTA);
    step("held_again",  0, 0, 0, 0, 4'd0,  S_FET, O_INTS);
    step("held_push2",  0, 0, 0, 0, 4'd0,  S_INT, O_INTW);
    step("held_ack2",   0, 0, 0, 0, 4'd0,  S_INT, O_INTA);
    step("held_idle",   0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    // branch beats a pending interrupt, then reset mid INT_ENTRY
    step("bi_raise",    0, 0, 0, 1, 4'd0,  S_FET, O_IDLE);
    step("bi_branch",   0, 1, 0, 0, 4'd0,  S_FET, O_BUB);
    step("bi_fl1",      0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("bi_fl2",      0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("bi_start",    0, 0, 0, 0, 4'd0,  S_FET, O_INTS);
    step("bi_push",     0, 0, 0, 0, 4'd0,  S_INT, O_INTW);
    step("rst_mid_int", 1, 0, 0, 0, 4'd0,  S_RST, O_BUB);
    step("rst_rel_int", 0, 0, 0, 0, 4'd0,  S_RST, O_BUB);
    step("post_rst1",   0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);
    step("post_rst2",   0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);
`else
    // interrupts compiled out: requests are ignored everywhere
    step("noint_idle1", 0, 0, 0, 1, 4'd0,  S_FET, O_IDLE);
    step("noint_idle2", 0, 0, 0, 1, 4'd0,  S_FET, O_IDLE);
    step("noint_imm",   0, 0, 0, 1, 4'd12, S_FET, O_IMMS);
    step("noint_w1",    0, 0, 0, 1, 4'd0,  S_IMM, O_IMMV);
    step("noint_w2",    0, 0, 0, 1, 4'd0,  S_IMM, O_IMMV);
    step("noint_after", 0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);
`endif

    // reset in the middle of a flush abandons it
    step("rf_branch",   0, 1, 0, 0, 4'd0,  S_FET, O_BUB);
    step("rf_flush1",   0, 0, 0, 0, 4'd0,  S_FLS, O_BUB);
    step("rf_reset",    1, 0, 0, 0, 4'd0,  S_RST, O_BUB);
    step("rf_release",  0, 0, 0, 0, 4'd0,  S_RST, O_BUB);
    step("rf_fetch",    0, 0, 0, 0, 4'd0,  S_FET, O_IDLE);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
